// File: rtl/onehot_rr_arbiter.sv
// Parametrised N-way arbiter: registered one-hot grant plus binary index,
// round-robin or fixed-priority (highest index wins), valid/ready to the consumer.
module onehot_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int SEL_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int RR_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid,
  input  logic             grant_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SEL_W-1:0] search_base;
  logic [SEL_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [N_REQ-1:0] req_rot;
  logic             accept;
  logic             any_req;
  logic             load;
  int               offset;
  int               cand;

  // On accept the search starts just past the winner being retired, so the
  // reload in the same cycle already sees the advanced pointer.
  always_comb begin
    accept      = (state == BUSY) && grant_ready;
    any_req     = |req;
    search_base = rr_ptr;
    if (accept) begin
      search_base = (grant_idx == SEL_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    req_rot = N_REQ'({req, req} >> search_base);
    offset  = 0;
    cand    = 0;
    win_idx = '0;
    if (RR_MODE != 0) begin
      for (int j = N_REQ - 1; j >= 0; j--) begin
        if (req_rot[j]) offset = j;
      end
      cand = int'(search_base) + offset;
      if (cand >= N_REQ) cand = cand - N_REQ;
      win_idx = SEL_W'(cand);
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) win_idx = SEL_W'(i);
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (win_idx == SEL_W'(i));
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (grant_ready) begin
          if (RR_MODE != 0) rr_ptr_nxt = search_base;
          if (any_req) load = 1'b1;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (load) begin
        grant       <= win_onehot;
        grant_idx   <= win_idx;
        grant_valid <= 1'b1;
      end else if (accept) begin
        grant       <= '0;
        grant_idx   <= '0;
        grant_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter: round-robin N=4, fixed-priority N=4,
// and round-robin N=3 instances driven with directed vectors.
module tb_onehot_rr_arbiter;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [3:0] req_a = '0, grant_a;
  logic [1:0] idx_a;
  logic       valid_a, ready_a = 1'b0;

  logic [3:0] req_b = '0, grant_b;
  logic [1:0] idx_b;
  logic       valid_b, ready_b = 1'b0;

  logic [2:0] req_c = '0, grant_c;
  logic [1:0] idx_c;
  logic       valid_c, ready_c = 1'b0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.N_REQ(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .grant_idx(idx_a),
    .grant_valid(valid_a), .grant_ready(ready_a));

  onehot_rr_arbiter #(.N_REQ(4), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .grant_idx(idx_b),
    .grant_valid(valid_b), .grant_ready(ready_b));

  onehot_rr_arbiter #(.N_REQ(3), .RR_MODE(1)) u_rr3 (
    .clk(clk), .rst(rst), .req(req_c), .grant(grant_c), .grant_idx(idx_c),
    .grant_valid(valid_c), .grant_ready(ready_c));

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int dut, input logic [3:0] r, input logic rdy);
    case (dut)
      0: begin req_a = r;      ready_a = rdy; end
      1: begin req_b = r;      ready_b = rdy; end
      default: begin req_c = r[2:0]; ready_c = rdy; end
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkInvariant(input string name, input logic [3:0] g,
                                input logic [1:0] idx, input logic v);
    logic ok;
    ok = $onehot0(g) && (g[idx] == v) && (v || (idx == 2'd0));
    tests++;
    if (!ok) begin
      failed++;
      $display("[TB] FAIL %s: grant=%b idx=%0d valid=%b, required one-hot grant[idx]==valid", name, g, idx, v);
    end
  endtask

  task automatic scoreAccept(input string name, input logic [3:0] g,
                             input logic [1:0] idx, inout exp_t q[$]);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      failed++;
      $display("[TB] FAIL %s_unexpected: grant=%b idx=%0d, required no grant", name, g, idx);
    end else begin
      e = q.pop_front();
      if (g !== e.g || idx !== e.idx) begin
        failed++;
        $display("[TB] FAIL %s: grant=%b idx=%0d, required grant=%b idx=%0d", name, g, idx, e.g, e.idx);
      end
    end
  endtask

  // Consumes one expected entry per accepted grant, sampled mid-cycle.
  task automatic monitorScoreboard();
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkInvariant("inv_rr", grant_a, idx_a, valid_a);
        checkInvariant("inv_fp", grant_b, idx_b, valid_b);
        checkInvariant("inv_rr3", {1'b0, grant_c}, idx_c, valid_c);
        if (valid_a && ready_a) scoreAccept("rr_grant", grant_a, idx_a, q_a);
        if (valid_b && ready_b) scoreAccept("fp_grant", grant_b, idx_b, q_b);
        if (valid_c && ready_c) scoreAccept("rr3_grant", {1'b0, grant_c}, idx_c, q_c);
      end
    end
  endtask

  initial begin
    fork
      monitorScoreboard();
    join_none

    // Reset with all requests high
    rst = 1'b1;
    applyStimulus(0, 4'b1111, 1'b0);
    tick(2);
    checkOutput("reset_rr", {1'b0, valid_a, idx_a, grant_a}, 8'h00);
    checkOutput("reset_fp", {1'b0, valid_b, idx_b, grant_b}, 8'h00);
    checkOutput("reset_rr3", {1'b0, valid_c, idx_c, 1'b0, grant_c}, 8'h00);

    // Round-robin rotation with ready held high
    rst = 1'b0;
    q_a.push_back('{4'b0001, 2'd0});
    q_a.push_back('{4'b0010, 2'd1});
    q_a.push_back('{4'b0100, 2'd2});
    q_a.push_back('{4'b1000, 2'd3});
    q_a.push_back('{4'b0001, 2'd0});
    applyStimulus(0, 4'b1111, 1'b1);
    tick(5);
    applyStimulus(0, 4'b0000, 1'b1);
    tick(1);
    checkOutput("rr_idle_after_rotation", {7'd0, valid_a}, 8'h00);
    checkOutput("rr_queue_drained_1", 8'(q_a.size()), 8'h00);

    // Grant held under back-pressure even after the request drops
    applyStimulus(0, 4'b1010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("rr_hold", {1'b0, valid_a, idx_a, grant_a}, {1'b0, 1'b1, 2'd1, 4'b0010});
      if (i == 1) applyStimulus(0, 4'b1000, 1'b0);
    end
    q_a.push_back('{4'b0010, 2'd1});
    q_a.push_back('{4'b1000, 2'd3});
    applyStimulus(0, 4'b1000, 1'b1);
    tick(1);
    applyStimulus(0, 4'b0000, 1'b1);
    tick(1);
    checkOutput("rr_idle_after_hold", {7'd0, valid_a}, 8'h00);

    // Fixed priority: highest index wins every time
    q_b.push_back('{4'b0100, 2'd2});
    q_b.push_back('{4'b0100, 2'd2});
    q_b.push_back('{4'b0100, 2'd2});
    q_b.push_back('{4'b0001, 2'd0});
    applyStimulus(1, 4'b0110, 1'b1);
    tick(3);
    applyStimulus(1, 4'b0001, 1'b1);
    tick(1);
    applyStimulus(1, 4'b0000, 1'b1);
    tick(1);
    checkOutput("fp_idle", {7'd0, valid_b}, 8'h00);
    checkOutput("fp_ptr_held_zero", {6'd0, u_fp.rr_ptr}, 8'h00);

    // Non-power-of-two round robin wraps at 3
    q_c.push_back('{4'b0001, 2'd0});
    q_c.push_back('{4'b0010, 2'd1});
    q_c.push_back('{4'b0100, 2'd2});
    q_c.push_back('{4'b0001, 2'd0});
    q_c.push_back('{4'b0010, 2'd1});
    applyStimulus(2, 4'b0111, 1'b1);
    tick(5);
    applyStimulus(2, 4'b0000, 1'b1);
    tick(1);
    checkOutput("rr3_idle", {7'd0, valid_c}, 8'h00);
    checkOutput("rr3_ptr_after_idx1", {6'd0, u_rr3.rr_ptr}, 8'h02);

    // Reset while a grant is pending
    q_a.push_back('{4'b0010, 2'd1});
    applyStimulus(0, 4'b0010, 1'b1);
    tick(1);
    applyStimulus(0, 4'b1111, 1'b1);
    tick(1);
    applyStimulus(0, 4'b1111, 1'b0);
    checkOutput("rr_pending_grant", {1'b0, valid_a, idx_a, grant_a}, {1'b0, 1'b1, 2'd2, 4'b0100});
    checkOutput("rr_ptr_before_reset", {6'd0, u_rr.rr_ptr}, 8'h02);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rr_midgrant_reset", {1'b0, valid_a, idx_a, grant_a}, 8'h00);
    checkOutput("rr_ptr_after_reset", {6'd0, u_rr.rr_ptr}, 8'h00);
    q_a.push_back('{4'b1000, 2'd3});
    applyStimulus(0, 4'b1000, 1'b1);
    tick(1);
    applyStimulus(0, 4'b0000, 1'b1);
    tick(2);
    checkOutput("rr_idle_final", {7'd0, valid_a}, 8'h00);

    checkOutput("rr_queue_drained", 8'(q_a.size()), 8'h00);
    checkOutput("fp_queue_drained", 8'(q_b.size()), 8'h00);
    checkOutput("rr3_queue_drained", 8'(q_c.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
